// File: rtl/preproc_regs_pkg.sv
// Shared definitions for the preprocessing register block.
// Holds the register byte addresses, AXI response codes, the write/read
// FSM state encodings and a small word-decode helper.
package preproc_regs_pkg;

  // Register byte addresses. Only bits [3:2] select a register.
  localparam logic [3:0] ADDR_OFFSET     = 4'h0;
  localparam logic [3:0] ADDR_SEL_SOURCE = 4'h4;
  localparam logic [3:0] ADDR_CTRL       = 4'h8;
  localparam logic [3:0] ADDR_STATUS     = 4'hC;

  // AXI response codes.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  // Word index of a byte address. The byte lane bits are ignored.
  function automatic logic [1:0] word_of(input logic [3:0] byte_addr);
    return byte_addr[3:2];
  endfunction

endpackage

// File: rtl/preproc_axil_regs.sv
// AXI4-Lite register slave for the preprocessing datapath.
//
// Registers:
//   0x0 OFFSET      RW  [15:0]  DC offset
//   0x4 SEL_SOURCE  RW  [4:0]   source mux select
//   0x8 CTRL        RW  [0] enable, W1 [1] soft clear (reads 0)
//   0xC STATUS      RO          live status_i (writes get SLVERR)
//
// Ports:
//   s_axi_aclk / s_axi_aresetn   clock, asynchronous active-low reset
//   s_axi_aw* / s_axi_w* / s_axi_b*  write address, data and response
//   s_axi_ar* / s_axi_r*             read address and data
//   offset_o, sel_source_o, enable_o, soft_clr_o  register outputs (flops)
//   status_i                     live status word
module preproc_axil_regs
  import preproc_regs_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 4,
  parameter int WSTRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                   s_axi_aclk,
  input  logic                   s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]  s_axi_awaddr,
  input  logic                   s_axi_awvalid,
  output logic                   s_axi_awready,
  input  logic [DATA_WIDTH-1:0]  s_axi_wdata,
  input  logic [WSTRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                   s_axi_wvalid,
  output logic                   s_axi_wready,
  output logic [1:0]             s_axi_bresp,
  output logic                   s_axi_bvalid,
  input  logic                   s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]  s_axi_araddr,
  input  logic                   s_axi_arvalid,
  output logic                   s_axi_arready,
  output logic [DATA_WIDTH-1:0]  s_axi_rdata,
  output logic [1:0]             s_axi_rresp,
  output logic                   s_axi_rvalid,
  input  logic                   s_axi_rready,
  output logic [15:0]            offset_o,
  output logic [4:0]             sel_source_o,
  output logic                   enable_o,
  output logic                   soft_clr_o,
  input  logic [31:0]            status_i
);

  // Write channel state
  w_state_e               w_state_q, w_state_d;
  logic                   aw_latched_q, aw_latched_d;
  logic                   w_latched_q, w_latched_d;
  logic [ADDR_WIDTH-1:0]  awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [WSTRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                   awready_q, awready_d;
  logic                   wready_q, wready_d;
  logic                   bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d;

  // Read channel state
  r_state_e               r_state_q, r_state_d;
  logic                   arready_q, arready_d;
  logic                   rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [1:0]             rresp_q, rresp_d;

  // Register file
  logic [15:0]            offset_q, offset_d;
  logic [4:0]             sel_source_q, sel_source_d;
  logic                   enable_q, enable_d;
  logic                   soft_clr_q, soft_clr_d;

  // Handshakes and the effective address/data of the write being committed.
  // A channel that handshakes on this edge supplies its bus value directly,
  // otherwise the previously latched copy is used.
  logic                   aw_hs, w_hs, ar_hs;
  logic                   aw_have, w_have;
  logic [ADDR_WIDTH-1:0]  commit_addr;
  logic [DATA_WIDTH-1:0]  commit_data;
  logic [WSTRB_WIDTH-1:0] commit_strb;
  logic [DATA_WIDTH-1:0]  read_word;
  logic                   unused_bits;

  assign aw_hs       = s_axi_awvalid && awready_q;
  assign w_hs        = s_axi_wvalid && wready_q;
  assign ar_hs       = s_axi_arvalid && arready_q;
  assign aw_have     = aw_latched_q || aw_hs;
  assign w_have      = w_latched_q || w_hs;
  assign commit_addr = aw_hs ? s_axi_awaddr : awaddr_q;
  assign commit_data = w_hs ? s_axi_wdata : wdata_q;
  assign commit_strb = w_hs ? s_axi_wstrb : wstrb_q;

  assign unused_bits = ^{commit_addr[1:0], commit_data[DATA_WIDTH-1:16],
                         commit_strb[WSTRB_WIDTH-1:2], s_axi_araddr[1:0]};

  // Write FSM: collect AW and W in either order, commit when both are
  // present, then hold the response until the master takes it.
  always_comb begin
    w_state_d    = w_state_q;
    aw_latched_d = aw_latched_q;
    w_latched_d  = w_latched_q;
    awaddr_d     = awaddr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    awready_d    = awready_q;
    wready_d     = wready_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    offset_d     = offset_q;
    sel_source_d = sel_source_q;
    enable_d     = enable_q;
    soft_clr_d   = 1'b0;

    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs) awaddr_d = s_axi_awaddr;
        if (w_hs) begin
          wdata_d = s_axi_wdata;
          wstrb_d = s_axi_wstrb;
        end
        if (aw_have && w_have) begin
          w_state_d    = W_RESP;
          aw_latched_d = 1'b0;
          w_latched_d  = 1'b0;
          awready_d    = 1'b0;
          wready_d     = 1'b0;
          bvalid_d     = 1'b1;
          bresp_d      = RESP_OKAY;
          unique case (word_of(commit_addr[3:0]))
            word_of(ADDR_OFFSET): begin
              if (commit_strb[0]) offset_d[7:0]  = commit_data[7:0];
              if (commit_strb[1]) offset_d[15:8] = commit_data[15:8];
            end
            word_of(ADDR_SEL_SOURCE): begin
              if (commit_strb[0]) sel_source_d = commit_data[4:0];
            end
            word_of(ADDR_CTRL): begin
              if (commit_strb[0]) begin
                enable_d   = commit_data[0];
                soft_clr_d = commit_data[1];
              end
            end
            default: bresp_d = RESP_SLVERR;
          endcase
        end else begin
          aw_latched_d = aw_have;
          w_latched_d  = w_have;
          awready_d    = !aw_have;
          wready_d     = !w_have;
        end
      end
      W_RESP: begin
        if (bvalid_q && s_axi_bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read mux sees the register flops, so a write committing on the same
  // edge as the read handshake is not yet visible to that read.
  always_comb begin
    read_word = '0;
    unique case (word_of(s_axi_araddr[3:0]))
      word_of(ADDR_OFFSET):     read_word[15:0] = offset_q;
      word_of(ADDR_SEL_SOURCE): read_word[4:0]  = sel_source_q;
      word_of(ADDR_CTRL):       read_word[0]    = enable_q;
      default:                  read_word[31:0] = status_i;
    endcase
  end

  // Read FSM: one-cycle latency from address handshake to rvalid.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    unique case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          r_state_d = R_DATA;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = read_word;
          rresp_d   = RESP_OKAY;
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Ready flags are registered so they stay low throughout reset and rise
  // on the first clock edge after release.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_state_q    <= W_IDLE;
      aw_latched_q <= 1'b0;
      w_latched_q  <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= 2'b00;
      r_state_q    <= R_IDLE;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      rresp_q      <= 2'b00;
      offset_q     <= '0;
      sel_source_q <= '0;
      enable_q     <= 1'b0;
      soft_clr_q   <= 1'b0;
    end else begin
      w_state_q    <= w_state_d;
      aw_latched_q <= aw_latched_d;
      w_latched_q  <= w_latched_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      r_state_q    <= r_state_d;
      arready_q    <= arready_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      offset_q     <= offset_d;
      sel_source_q <= sel_source_d;
      enable_q     <= enable_d;
      soft_clr_q   <= soft_clr_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign offset_o      = offset_q;
  assign sel_source_o  = sel_source_q;
  assign enable_o      = enable_q;
  assign soft_clr_o    = soft_clr_q;

endmodule

// File: tb/tb_preproc_axil_regs.sv
// Directed testbench for preproc_axil_regs.
module tb_preproc_axil_regs;

  logic        clk;
  logic        rst_n;
  logic [3:0]  s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [3:0]  s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [15:0] offset_o;
  logic [4:0]  sel_source_o;
  logic        enable_o;
  logic        soft_clr_o;
  logic [31:0] status_i;

  int checks = 0;
  int failures = 0;
  int pulseCount = 0;

  preproc_axil_regs dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .offset_o      (offset_o),
    .sel_source_o  (sel_source_o),
    .enable_o      (enable_o),
    .soft_clr_o    (soft_clr_o),
    .status_i      (status_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count soft clear pulse cycles, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && soft_clr_o) pulseCount = pulseCount + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One AXI write; AW is raised awLag cycles and W wLag cycles after start.
  task automatic applyStimulus(input logic [3:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input int awLag,
                               input int wLag, output logic [1:0] resp);
    bit awDone, wDone, awFire, wFire;
    int waitCnt;
    awDone = 0;
    wDone  = 0;
    resp   = 2'b11;
    for (int c = 0; c < 40 && !(awDone && wDone); c++) begin
      if (c == awLag) begin
        s_axi_awaddr  = addr;
        s_axi_awvalid = 1'b1;
      end
      if (c == wLag) begin
        s_axi_wdata  = data;
        s_axi_wstrb  = strb;
        s_axi_wvalid = 1'b1;
      end
      awFire = s_axi_awvalid && s_axi_awready;
      wFire  = s_axi_wvalid && s_axi_wready;
      tick(1);
      if (awFire) begin
        s_axi_awvalid = 1'b0;
        awDone = 1;
      end
      if (wFire) begin
        s_axi_wvalid = 1'b0;
        wDone = 1;
      end
    end
    if (!(awDone && wDone)) begin
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      checkOutput("aw_w_timeout", 32'd0, 32'd1);
      return;
    end
    waitCnt = 0;
    while (!s_axi_bvalid && waitCnt < 20) begin
      tick(1);
      waitCnt++;
    end
    if (!s_axi_bvalid) begin
      checkOutput("bvalid_timeout", 32'd0, 32'd1);
      return;
    end
    resp = s_axi_bresp;
    s_axi_bready = 1'b1;
    tick(1);
    s_axi_bready = 1'b0;
  endtask

  task automatic applyRead(input logic [3:0] addr, output logic [31:0] data);
    bit arDone, arFire;
    int waitCnt;
    arDone = 0;
    data   = 32'hXXXX_XXXX;
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    for (int c = 0; c < 20 && !arDone; c++) begin
      arFire = s_axi_arvalid && s_axi_arready;
      tick(1);
      if (arFire) begin
        s_axi_arvalid = 1'b0;
        arDone = 1;
      end
    end
    if (!arDone) begin
      s_axi_arvalid = 1'b0;
      checkOutput("ar_timeout", 32'd0, 32'd1);
      return;
    end
    waitCnt = 0;
    while (!s_axi_rvalid && waitCnt < 20) begin
      tick(1);
      waitCnt++;
    end
    if (!s_axi_rvalid) begin
      checkOutput("rvalid_timeout", 32'd0, 32'd1);
      return;
    end
    data = s_axi_rdata;
    checkOutput("rresp_okay", {30'd0, s_axi_rresp}, 32'd0);
    s_axi_rready = 1'b1;
    tick(1);
    s_axi_rready = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_readys"}, {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd0);
    checkOutput({tag, "_valids"}, {30'd0, s_axi_bvalid, s_axi_rvalid}, 32'd0);
    checkOutput({tag, "_resps"}, {28'd0, s_axi_bresp, s_axi_rresp}, 32'd0);
    checkOutput({tag, "_rdata"}, s_axi_rdata, 32'd0);
    checkOutput({tag, "_offset"}, {16'd0, offset_o}, 32'd0);
    checkOutput({tag, "_regs"}, {25'd0, sel_source_o, enable_o, soft_clr_o}, 32'd0);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    logic [31:0] first;
    logic [1:0]  firstResp;
    bit          stable;
    int          pulseBase;

    rst_n = 1'b0;
    s_axi_awaddr = '0; s_axi_awvalid = 0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 0;
    s_axi_bready = 0;
    s_axi_araddr = '0; s_axi_arvalid = 0; s_axi_rready = 0;
    status_i = 32'h0000_0000;

    #22;
    checkResetOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    checkOutput("ready_after_reset", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h7);

    // OFFSET: AW first, W three cycles later
    applyStimulus(4'h0, 32'h0000_1234, 4'b1111, 0, 3, resp);
    checkOutput("offset_bresp", {30'd0, resp}, 32'd0);
    checkOutput("offset_out", {16'd0, offset_o}, 32'h0000_1234);
    applyRead(4'h0, rd);
    checkOutput("offset_read", rd, 32'h0000_1234);

    // SEL_SOURCE strobe handling
    applyStimulus(4'h4, 32'h0000_0005, 4'b1111, 0, 0, resp);
    checkOutput("sel_first", {27'd0, sel_source_o}, 32'h05);
    applyStimulus(4'h4, 32'h0000_001F, 4'b0000, 0, 0, resp);
    checkOutput("sel_strb0_keeps", {27'd0, sel_source_o}, 32'h05);
    applyStimulus(4'h4, 32'h0000_00FF, 4'b0001, 1, 0, resp);
    checkOutput("sel_strb1", {27'd0, sel_source_o}, 32'h1F);
    applyRead(4'h4, rd);
    checkOutput("sel_read", rd, 32'h0000_001F);

    // CTRL: enable plus single-cycle soft clear
    pulseBase = pulseCount;
    applyStimulus(4'h8, 32'h0000_0003, 4'b1111, 0, 0, resp);
    tick(3);
    checkOutput("ctrl_enable", {31'd0, enable_o}, 32'd1);
    checkOutput("soft_clr_pulses", pulseCount - pulseBase, 32'd1);
    applyRead(4'h8, rd);
    checkOutput("ctrl_read", rd, 32'h0000_0001);
    pulseBase = pulseCount;
    applyStimulus(4'h8, 32'h0000_0002, 4'b0000, 0, 0, resp);
    tick(2);
    checkOutput("ctrl_strb0_no_pulse", pulseCount - pulseBase, 32'd0);
    checkOutput("ctrl_strb0_enable", {31'd0, enable_o}, 32'd1);

    // STATUS is read-only
    status_i = 32'hCAFE_0001;
    applyStimulus(4'hC, 32'h0000_DEAD, 4'b1111, 0, 0, resp);
    checkOutput("status_bresp", {30'd0, resp}, 32'h2);
    checkOutput("status_no_side_effect", {16'd0, offset_o}, 32'h0000_1234);
    applyRead(4'hC, rd);
    checkOutput("status_read", rd, 32'hCAFE_0001);

    // W before AW, low byte lanes of address ignored, byte 1 only
    applyStimulus(4'h1, 32'hABCD_5678, 4'b0010, 2, 0, resp);
    checkOutput("offset_byte1", {16'd0, offset_o}, 32'h0000_5634);

    // Write response stall
    s_axi_awaddr = 4'hC; s_axi_awvalid = 1;
    s_axi_wdata = 32'h1; s_axi_wstrb = 4'hF; s_axi_wvalid = 1;
    tick(1);
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    checkOutput("bstall_bvalid", {31'd0, s_axi_bvalid}, 32'd1);
    firstResp = s_axi_bresp;
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      if (!s_axi_bvalid || s_axi_bresp !== firstResp || s_axi_awready || s_axi_wready)
        stable = 0;
      tick(1);
    end
    checkOutput("bstall_stable", {31'd0, stable}, 32'd1);
    checkOutput("bstall_bresp", {30'd0, firstResp}, 32'h2);
    s_axi_bready = 1;
    tick(1);
    s_axi_bready = 0;
    checkOutput("bstall_ready_back", {30'd0, s_axi_awready, s_axi_wready}, 32'h3);

    // Read data stall
    s_axi_araddr = 4'h0; s_axi_arvalid = 1;
    tick(1);
    s_axi_arvalid = 0;
    first = s_axi_rdata;
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      if (!s_axi_rvalid || s_axi_rdata !== first || s_axi_arready) stable = 0;
      tick(1);
    end
    checkOutput("rstall_stable", {31'd0, stable}, 32'd1);
    checkOutput("rstall_data", first, 32'h0000_5634);
    s_axi_rready = 1;
    tick(1);
    s_axi_rready = 0;

    // Read and write of OFFSET on the same edge
    s_axi_awaddr = 4'h0; s_axi_awvalid = 1;
    s_axi_wdata = 32'h0000_9ABC; s_axi_wstrb = 4'hF; s_axi_wvalid = 1;
    s_axi_araddr = 4'h0; s_axi_arvalid = 1;
    tick(1);
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
    checkOutput("same_edge_valids", {30'd0, s_axi_bvalid, s_axi_rvalid}, 32'h3);
    checkOutput("same_edge_old_value", s_axi_rdata, 32'h0000_5634);
    s_axi_bready = 1; s_axi_rready = 1;
    tick(1);
    s_axi_bready = 0; s_axi_rready = 0;
    checkOutput("same_edge_new_offset", {16'd0, offset_o}, 32'h0000_9ABC);

    // Reset with AW latched and W pending
    s_axi_awaddr = 4'h0; s_axi_awvalid = 1;
    tick(1);
    s_axi_awvalid = 0;
    s_axi_wdata = 32'h0000_7777; s_axi_wstrb = 4'hF; s_axi_wvalid = 1;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    tick(6);
    s_axi_wvalid = 0;
    checkOutput("midreset_no_bvalid", {31'd0, s_axi_bvalid}, 32'd0);
    checkOutput("midreset_no_commit", {16'd0, offset_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/preproc_axil_regs.md
PREPROC_AXIL_REGS -- requirements
Module: preproc_axil_regs

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, 32, AXI4-Lite data width (only 32 supported); ADDR_WIDTH, 4, byte-address width; WSTRB_WIDTH, DATA_WIDTH/8, strobe width.
REQ-002 SHALL have ports s_axi_aclk (in, 1, sole clock, 100 MHz nominal) and s_axi_aresetn (in, 1, asynchronous active-low reset), in that order.
REQ-003 SHALL have write-address ports: s_axi_awaddr in ADDR_WIDTH; s_axi_awvalid in 1; s_axi_awready out 1.
REQ-004 SHALL have write-data ports: s_axi_wdata in DATA_WIDTH; s_axi_wstrb in WSTRB_WIDTH; s_axi_wvalid in 1; s_axi_wready out 1.
REQ-005 SHALL have write-response ports: s_axi_bresp out 2; s_axi_bvalid out 1; s_axi_bready in 1.
REQ-006 SHALL have read ports: s_axi_araddr in ADDR_WIDTH; s_axi_arvalid in 1; s_axi_arready out 1; s_axi_rdata out DATA_WIDTH; s_axi_rresp out 2; s_axi_rvalid out 1; s_axi_rready in 1.
REQ-007 SHALL have register outputs offset_o (out, 16, DC offset to preprocessing datapath), sel_source_o (out, 5, source mux select), enable_o (out, 1), soft_clr_o (out, 1, one-cycle clear pulse), plus status_i (in, 32, live status word).

Function
REQ-008 SHALL decode word address awaddr/araddr[3:2]: 0x0 OFFSET (RW, bits 15:0), 0x4 SEL_SOURCE (RW, bits 4:0), 0x8 CTRL (RW bit0 enable; W1 bit1 soft clear, reads 0), 0xC STATUS (RO, status_i); addr[1:0] ignored.
REQ-009 SHALL implement unimplemented RW bits as read-zero, write-ignored.
REQ-010 SHALL use write FSM W_IDLE -> W_RESP: in W_IDLE awready=1 until AW accepted and wready=1 until W accepted, each latched independently in any order or same cycle; when both latched, commit on that edge and enter W_RESP.
REQ-011 SHALL in W_RESP hold awready=wready=0 and bvalid=1 with stable bresp until bvalid&&bready, then return to W_IDLE (no new AW/W accepted that cycle).
REQ-012 SHALL apply wstrb per byte; a byte with strobe 0 keeps its old value.
REQ-013 SHALL respond bresp=OKAY (2'b00) for 0x0/0x4/0x8 and SLVERR (2'b10) for write to 0xC, which changes nothing.
REQ-014 SHALL assert soft_clr_o for exactly one cycle, the cycle after a committed CTRL write with wstrb[0]=1 and wdata[1]=1.
REQ-015 SHALL use read FSM R_IDLE -> R_DATA: arready=1 in R_IDLE; on arvalid&&arready capture rdata (status_i sampled that edge), rresp=OKAY, enter R_DATA (1-cycle latency to rvalid).
REQ-016 SHALL in R_DATA hold arready=0, rvalid=1, rdata/rresp stable until rready, then return to R_IDLE.
REQ-017 SHALL, when a read and write to the same register handshake on the same edge, return the pre-write value.
REQ-018 SHALL drive register outputs directly from flops (no combinational path from AXI inputs).

Reset
REQ-019 SHALL on s_axi_aresetn low, asynchronously: both FSMs idle, awready=wready=arready=0 during reset, bvalid=rvalid=0, bresp=rresp=0, rdata=0, offset_o=0, sel_source_o=0, enable_o=0, soft_clr_o=0, AW/W latches cleared.
REQ-020 SHALL assert awready/wready/arready on the first edge after release; reset mid-transaction abandons it with no partial commit.

Structure
REQ-021 SHALL place register word addresses (0x0/0x4/0x8/0xC), RESP_OKAY/RESP_SLVERR, and FSM state enums in a shared package preproc_regs_pkg.
REQ-022 SHALL be a single module; no sub-modules required.

Verification
REQ-023 Write 0x0 data 0x0000_1234 strb 4'b1111, AW then W 3 cycles later -> bresp OKAY, offset_o=0x1234; read 0x0 returns 0x0000_1234.
REQ-024 Write 0x4 data 0x1F strb 4'b0000 after prior 0x05 -> sel_source_o stays 0x05; write 0x4 data 0xFF strb 4'b0001 -> reads 0x0000_001F.
REQ-025 Write 0x8 data 0x3 -> enable_o=1, soft_clr_o high exactly 1 cycle; read 0x8 returns 0x1.
REQ-026 Write 0xC data 0xDEAD -> bresp SLVERR; with status_i=0xCAFE_0001 read 0xC returns 0xCAFE_0001.
REQ-027 bready held low 10 cycles -> bvalid and bresp stable, awready/wready=0; rready low 10 cycles -> rdata stable.
REQ-028 Assert s_axi_aresetn low with AW latched, W pending -> all outputs per REQ-019 immediately; later W alone produces no commit.
